// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-to-controller bundle: decode operands, in-flight writers, branch, and control/debug outputs.
// The slave modport is the controller; the master modport is the pipeline datapath.
interface hazard_stall_ctrl_if #(
    parameter int ASIZE = 4,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [ASIZE-1:0] id_rs1;
    logic [ASIZE-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_wen;
    logic [ASIZE-1:0] ex_waddr;
    logic             dm_wen;
    logic [ASIZE-1:0] dm_waddr;
    logic             wb_wen;
    logic [ASIZE-1:0] wb_waddr;
    logic             br_taken;
    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_bubble;
    logic             flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_wen, ex_waddr, dm_wen, dm_waddr, wb_wen, wb_waddr, br_taken,
        input  pc_hold, ifid_hold, idex_bubble, flush, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_wen, ex_waddr, dm_wen, dm_waddr, wb_wen, wb_waddr, br_taken,
        output pc_hold, ifid_hold, idex_bubble, flush, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// RAW-hazard stall and taken-branch flush sequencer for the IF/ID/EXE + DM + WB pipeline.
//   state | meaning
//   RUN   | normal issue; hazard detection live, outputs may assert combinationally
//   STALL | holding fetch/decode and bubbling ID_EXE until the producer reaches the regfile
//   FLUSH | squashing wrong-path fetches after a taken branch
module hazard_stall_ctrl #(
    parameter int ASIZE         = 4,
    parameter int WRITE_THROUGH = 0,
    parameter int FLUSH_CYCLES  = 2,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_STALL = 2'b01,
        S_FLUSH = 2'b10
    } state_t;

    localparam int             RW         = 8;
    localparam logic [RW-1:0]  FLUSH_INIT = RW'(FLUSH_CYCLES - 1);
    localparam logic [1:0]     WB_DEPTH   = (WRITE_THROUGH != 0) ? 2'd0 : 2'd1;

    state_t           r_state, w_next_state;
    logic [RW-1:0]    r_remain, w_next_remain;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_hit_ex, w_hit_dm, w_hit_wb;
    logic [1:0]       w_depth;
    logic             w_hold, w_bubble, w_flush;

    function automatic logic f_hit(input logic wen, input logic [ASIZE-1:0] waddr,
                                   input logic valid, input logic use1, input logic [ASIZE-1:0] rs1,
                                   input logic use2, input logic [ASIZE-1:0] rs2);
        return valid & wen & ((use1 & (rs1 == waddr)) | (use2 & (rs2 == waddr)));
    endfunction

    assign w_hit_ex = f_hit(bus.ex_wen, bus.ex_waddr, bus.id_valid, bus.id_use_rs1, bus.id_rs1,
                            bus.id_use_rs2, bus.id_rs2);
    assign w_hit_dm = f_hit(bus.dm_wen, bus.dm_waddr, bus.id_valid, bus.id_use_rs1, bus.id_rs1,
                            bus.id_use_rs2, bus.id_rs2);
    assign w_hit_wb = f_hit(bus.wb_wen, bus.wb_waddr, bus.id_valid, bus.id_use_rs1, bus.id_rs1,
                            bus.id_use_rs2, bus.id_rs2);

    // Youngest producer dictates how long decode must wait.
    always_comb begin
        w_depth = 2'd0;
        if (w_hit_ex)      w_depth = 2'd3;
        else if (w_hit_dm) w_depth = 2'd2;
        else if (w_hit_wb) w_depth = WB_DEPTH;
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_remain = r_remain;
        w_hold        = 1'b0;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        if (bus.br_taken && r_state != S_FLUSH) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_next_state  = S_FLUSH;
                w_next_remain = FLUSH_INIT;
            end else begin
                w_next_state  = S_RUN;
                w_next_remain = '0;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_depth != 2'd0) begin
                        w_hold   = 1'b1;
                        w_bubble = 1'b1;
                        if (w_depth > 2'd1) begin
                            w_next_state  = S_STALL;
                            w_next_remain = RW'(w_depth) - RW'(1);
                        end
                    end
                end
                S_STALL: begin
                    w_hold        = 1'b1;
                    w_bubble      = 1'b1;
                    w_next_remain = r_remain - RW'(1);
                    if (r_remain <= RW'(1)) w_next_state = S_RUN;
                end
                S_FLUSH: begin
                    w_flush       = 1'b1;
                    w_bubble      = 1'b1;
                    w_next_remain = r_remain - RW'(1);
                    if (r_remain <= RW'(1)) w_next_state = S_RUN;
                end
                default: begin
                    w_next_state  = S_RUN;
                    w_next_remain = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_remain    <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_remain <= w_next_remain;
            if (w_hold && r_stall_cnt != '1)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    // Mealy terms are masked by reset so nothing leaks out while rst is low.
    assign bus.pc_hold     = rst & w_hold;
    assign bus.ifid_hold   = rst & w_hold;
    assign bus.idex_bubble = rst & w_bubble;
    assign bus.flush       = rst & w_flush;
    assign bus.state       = r_state;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: main instance (WRITE_THROUGH=0, 16-bit counters) plus a write-through
// instance with 2-bit counters so saturation is reachable in a few cycles.
module tb_hazard_stall_ctrl;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    hazard_stall_ctrl_if #(.ASIZE(4), .CNT_W(16)) b0 ();
    hazard_stall_ctrl_if #(.ASIZE(4), .CNT_W(2))  b1 ();

    hazard_stall_ctrl #(.ASIZE(4), .WRITE_THROUGH(0), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );
    hazard_stall_ctrl #(.ASIZE(4), .WRITE_THROUGH(1), .FLUSH_CYCLES(2), .CNT_W(2)) dut_wt (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle0();
        b0.id_valid = 0; b0.id_rs1 = 0; b0.id_rs2 = 0; b0.id_use_rs1 = 0; b0.id_use_rs2 = 0;
        b0.ex_wen = 0; b0.ex_waddr = 0; b0.dm_wen = 0; b0.dm_waddr = 0;
        b0.wb_wen = 0; b0.wb_waddr = 0; b0.br_taken = 0;
    endtask

    task automatic idle1();
        b1.id_valid = 0; b1.id_rs1 = 0; b1.id_rs2 = 0; b1.id_use_rs1 = 0; b1.id_use_rs2 = 0;
        b1.ex_wen = 0; b1.ex_waddr = 0; b1.dm_wen = 0; b1.dm_waddr = 0;
        b1.wb_wen = 0; b1.wb_waddr = 0; b1.br_taken = 0;
    endtask

    task automatic ex_hit1(input logic [3:0] r);
        b1.id_valid = 1; b1.id_use_rs1 = 1; b1.id_rs1 = r; b1.ex_wen = 1; b1.ex_waddr = r;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        idle0();
        idle1();

        // Reset with a live EXE hazard and a branch: everything must stay quiet.
        b0.id_valid = 1; b0.id_use_rs1 = 1; b0.id_rs1 = 3; b0.ex_wen = 1; b0.ex_waddr = 3;
        b0.br_taken = 1;
        @(negedge clk); @(negedge clk);
        chk("rst_pc_hold", 16'(b0.pc_hold), 16'd0);
        chk("rst_ifid_hold", 16'(b0.ifid_hold), 16'd0);
        chk("rst_bubble", 16'(b0.idex_bubble), 16'd0);
        chk("rst_flush", 16'(b0.flush), 16'd0);
        chk("rst_state", 16'(b0.state), 16'd0);
        chk("rst_stall_cnt", b0.stall_cnt, 16'd0);
        chk("rst_flush_cnt", b0.flush_cnt, 16'd0);
        b0.br_taken = 0;

        // N0: release; EXE hazard holds in the same cycle.
        rst = 1'b1;
        #1;
        chk("ex_hold_c0", 16'(b0.pc_hold), 16'd1);
        chk("ex_bubble_c0", 16'(b0.idex_bubble), 16'd1);
        chk("ex_state_c0", 16'(b0.state), 16'd0);
        @(negedge clk);                                   // N1
        idle0();
        #1;
        chk("ex_state_c1", 16'(b0.state), 16'd1);
        chk("ex_hold_c1", 16'(b0.pc_hold), 16'd1);
        chk("ex_cnt_c1", b0.stall_cnt, 16'd1);
        @(negedge clk);                                   // N2
        chk("ex_hold_c2", 16'(b0.ifid_hold), 16'd1);
        chk("ex_state_c2", 16'(b0.state), 16'd1);
        @(negedge clk);                                   // N3
        chk("ex_hold_done", 16'(b0.pc_hold), 16'd0);
        chk("ex_state_done", 16'(b0.state), 16'd0);
        chk("ex_cnt_done", b0.stall_cnt, 16'd3);

        // WB hazard via rs2: one-cycle hold, state stays RUN.
        b0.id_valid = 1; b0.id_use_rs2 = 1; b0.id_rs2 = 5; b0.wb_wen = 1; b0.wb_waddr = 5;
        #1;
        chk("wb_hold", 16'(b0.pc_hold), 16'd1);
        @(negedge clk);                                   // N4
        chk("wb_state", 16'(b0.state), 16'd0);
        idle0();
        #1;
        chk("wb_release", 16'(b0.pc_hold), 16'd0);
        chk("wb_cnt", b0.stall_cnt, 16'd4);

        // EXE and DM both hit: depth 3 means STALL still on the second cycle.
        b0.id_valid = 1; b0.id_use_rs1 = 1; b0.id_rs1 = 7;
        b0.ex_wen = 1; b0.ex_waddr = 7; b0.dm_wen = 1; b0.dm_waddr = 7;
        #1;
        chk("prio_hold", 16'(b0.pc_hold), 16'd1);
        @(negedge clk);                                   // N5
        idle0();
        @(negedge clk);                                   // N6
        chk("prio_state_c2", 16'(b0.state), 16'd1);
        @(negedge clk);                                   // N7
        chk("prio_state_done", 16'(b0.state), 16'd0);
        chk("prio_cnt", b0.stall_cnt, 16'd7);

        // rs1 match without use_rs1, and a match on an invalid slot: no stall.
        b0.id_valid = 1; b0.id_use_rs1 = 0; b0.id_rs1 = 2; b0.id_use_rs2 = 1; b0.id_rs2 = 9;
        b0.ex_wen = 1; b0.ex_waddr = 2;
        #1;
        chk("nouse_hold", 16'(b0.pc_hold), 16'd0);
        b0.id_valid = 0; b0.id_use_rs1 = 1;
        #1;
        chk("invalid_hold", 16'(b0.pc_hold), 16'd0);
        idle0();
        @(negedge clk);                                   // N8

        // DM-only hit: depth 2.
        b0.id_valid = 1; b0.id_use_rs2 = 1; b0.id_rs2 = 4; b0.dm_wen = 1; b0.dm_waddr = 4;
        #1;
        chk("dm_hold", 16'(b0.pc_hold), 16'd1);
        @(negedge clk);                                   // N9
        idle0();
        chk("dm_state_c1", 16'(b0.state), 16'd1);
        chk("dm_cnt_c1", b0.stall_cnt, 16'd8);
        @(negedge clk);                                   // N10
        chk("dm_state_done", 16'(b0.state), 16'd0);
        chk("dm_cnt", b0.stall_cnt, 16'd9);

        // Branch during STALL: flush wins, pending stall discarded.
        b0.id_valid = 1; b0.id_use_rs1 = 1; b0.id_rs1 = 3; b0.ex_wen = 1; b0.ex_waddr = 3;
        @(negedge clk);                                   // N11
        idle0();
        b0.br_taken = 1;
        #1;
        chk("br_state_pre", 16'(b0.state), 16'd1);
        chk("br_flush", 16'(b0.flush), 16'd1);
        chk("br_pc_hold", 16'(b0.pc_hold), 16'd0);
        chk("br_ifid_hold", 16'(b0.ifid_hold), 16'd0);
        chk("br_bubble", 16'(b0.idex_bubble), 16'd1);
        @(negedge clk);                                   // N12: FLUSH, branch and hazard ignored
        b0.id_valid = 1; b0.id_use_rs1 = 1; b0.id_rs1 = 6; b0.ex_wen = 1; b0.ex_waddr = 6;
        #1;
        chk("fl_state", 16'(b0.state), 16'd2);
        chk("fl_flush", 16'(b0.flush), 16'd1);
        chk("fl_pc_hold", 16'(b0.pc_hold), 16'd0);
        @(negedge clk);                                   // N13
        idle0();
        #1;
        chk("fl_state_done", 16'(b0.state), 16'd0);
        chk("fl_flush_done", 16'(b0.flush), 16'd0);
        chk("fl_cnt", b0.flush_cnt, 16'd2);
        chk("fl_stall_cnt", b0.stall_cnt, 16'd10);

        // Reset in the middle of a flush.
        b0.br_taken = 1;
        @(negedge clk);                                   // N14
        b0.br_taken = 0;
        chk("mid_state", 16'(b0.state), 16'd2);
        chk("mid_flush_cnt", b0.flush_cnt, 16'd3);
        rst = 1'b0;
        #1;
        chk("mid_rst_state", 16'(b0.state), 16'd0);
        chk("mid_rst_flush", 16'(b0.flush), 16'd0);
        chk("mid_rst_fcnt", b0.flush_cnt, 16'd0);
        chk("mid_rst_scnt", b0.stall_cnt, 16'd0);
        @(negedge clk);                                   // N15
        rst = 1'b1;
        #1;
        chk("post_rst_hold", 16'(b0.pc_hold), 16'd0);
        chk("post_rst_flush", 16'(b0.flush), 16'd0);
        chk("post_rst_state", 16'(b0.state), 16'd0);

        // Write-through instance: WB match never stalls.
        chk("wt_cnt_init", 16'(b1.stall_cnt), 16'd0);
        b1.id_valid = 1; b1.id_use_rs2 = 1; b1.id_rs2 = 5; b1.wb_wen = 1; b1.wb_waddr = 5;
        #1;
        chk("wt_wb_hold", 16'(b1.pc_hold), 16'd0);
        idle1();

        // 2-bit counter: three stall cycles reach 3, three more must not wrap.
        ex_hit1(4'd1);
        #1;
        chk("wt_ex_hold", 16'(b1.pc_hold), 16'd1);
        @(negedge clk);
        idle1();
        @(negedge clk); @(negedge clk);
        chk("wt_state_done", 16'(b1.state), 16'd0);
        chk("wt_cnt_3", 16'(b1.stall_cnt), 16'd3);
        ex_hit1(4'd2);
        @(negedge clk);
        idle1();
        chk("wt_sat_mid", 16'(b1.stall_cnt), 16'd3);
        @(negedge clk); @(negedge clk);
        chk("wt_sat_state", 16'(b1.state), 16'd0);
        chk("wt_sat_cnt", 16'(b1.stall_cnt), 16'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
